// File: rtl/conv_out_writeback_pkg.sv
// Shared types and constants for the conv_top output write-back stage.
// Lane widths, FIFO entry payload, FSM state encoding and the lane saturation helper.
package conv_out_writeback_pkg;

    localparam int unsigned LANE_W     = 16;
    localparam int unsigned DATA_W     = 128;
    localparam int unsigned LANES      = DATA_W / LANE_W;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CNT_W      = 16;

    typedef logic signed [LANE_W-1:0] lane_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } wb_state_t;

    // Clamp a one-bit-wider signed sum back into the lane range.
    function automatic lane_t sat_lane(input logic signed [LANE_W:0] sum);
        lane_t res;
        if (sum[LANE_W] != sum[LANE_W-1]) begin
            res = sum[LANE_W] ? lane_t'({1'b1, {(LANE_W-1){1'b0}}})
                              : lane_t'({1'b0, {(LANE_W-1){1'b1}}});
        end else begin
            res = sum[LANE_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/conv_out_writeback_fifo.sv
// conv_wb_fifo: synchronous FIFO of wb_entry_t with registered full/valid/count flags.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module conv_wb_fifo
    import conv_out_writeback_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  wb_entry_t              i_entry,
    output wb_entry_t              o_head,
    output logic                   o_full,
    output logic                   o_valid,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_LW = PTR_W + 1;

    wb_entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_LW-1:0]   r_count;
    logic                r_full;
    logic                r_valid;

    logic                w_pop_ok;
    logic                w_push_ok;
    logic [CNT_LW-1:0]   w_count_next;

    assign w_pop_ok     = i_pop && r_valid;
    assign w_push_ok    = i_push && (!r_full || w_pop_ok);
    assign w_count_next = r_count + CNT_LW'(w_push_ok) - CNT_LW'(w_pop_ok);

    // Storage, pointers and occupancy flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem    <= '{default: '0};
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_entry;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_LW'(DEPTH));
            r_valid <= (w_count_next != '0);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_valid = r_valid;
    assign o_count = r_count;

endmodule

// File: rtl/conv_out_writeback.sv
// conv_out_writeback: bias + saturate (+ optional ReLU) per lane, buffer, drain to output BRAM.
// Build option: define CONV_WB_RELU_EN to clamp negative lane results to zero.
module conv_out_writeback
    import conv_out_writeback_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bias_load,
    input  logic [DATA_W-1:0] bias_in,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] bram_wr_addr,
    input  logic [DATA_W-1:0] output_pixels,
    input  logic              tile_done,
    output logic              fifo_full,
    output logic              mem_wr_valid,
    input  logic              mem_wr_ready,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              tile_wb_done,
    output logic [CNT_W-1:0]  words_written,
    output logic              overflow_err
);

    logic [DATA_W-1:0]     r_bias;
    wb_state_t             r_state;
    wb_state_t             w_state_next;
    logic [CNT_W-1:0]      r_words;
    logic                  r_overflow;
    logic                  r_tile_wb_done;

    logic [DATA_W-1:0]     w_proc;
    wb_entry_t             w_entry;
    wb_entry_t             w_head;
    logic                  w_fifo_full;
    logic                  w_fifo_valid;
    logic [FIFO_CNT_W-1:0] w_count;
    logic                  w_pop;
    logic                  w_push_acc;
    logic                  w_drop;
    logic [FIFO_CNT_W-1:0] w_occ_next;
    logic                  w_empty_next;
    logic                  w_clr_cnt;

    // Bias register; a write in the load cycle still sees the previous bias.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bias <= '0;
        end else if (bias_load) begin
            r_bias <= bias_in;
        end
    end

    // Per-lane 17-bit add, saturate, optional ReLU.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        lane_t                   w_pix;
        lane_t                   w_b;
        logic signed [LANE_W:0]  w_sum;
        lane_t                   w_sat;

        assign w_pix = lane_t'(output_pixels[g*LANE_W +: LANE_W]);
        assign w_b   = lane_t'(r_bias[g*LANE_W +: LANE_W]);
        assign w_sum = {w_pix[LANE_W-1], w_pix} + {w_b[LANE_W-1], w_b};
        assign w_sat = sat_lane(w_sum);
`ifdef CONV_WB_RELU_EN
        assign w_proc[g*LANE_W +: LANE_W] = w_sat[LANE_W-1] ? '0 : w_sat;
`else
        assign w_proc[g*LANE_W +: LANE_W] = w_sat;
`endif
    end

    assign w_entry.addr = bram_wr_addr;
    assign w_entry.data = w_proc;

    conv_wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (write_en),
        .i_pop   (w_pop),
        .i_entry (w_entry),
        .o_head  (w_head),
        .o_full  (w_fifo_full),
        .o_valid (w_fifo_valid),
        .o_count (w_count)
    );

    assign w_pop        = w_fifo_valid && mem_wr_ready;
    assign w_push_acc   = write_en && (!w_fifo_full || w_pop);
    assign w_drop       = write_en && w_fifo_full && !w_pop;
    assign w_occ_next   = w_count + FIFO_CNT_W'(w_push_acc) - FIFO_CNT_W'(w_pop);
    assign w_empty_next = (w_occ_next == '0);

    // Tile sequencing: next state and counter-clear decision.
    always_comb begin
        w_state_next = r_state;
        w_clr_cnt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (tile_done) begin
                    w_state_next = FLUSH;
                    w_clr_cnt    = 1'b1;
                end else if (write_en) begin
                    w_state_next = RUN;
                    w_clr_cnt    = 1'b1;
                end
            end
            RUN: begin
                if (tile_done) begin
                    w_state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (w_empty_next) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State, tile counter, sticky overflow and completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_words        <= '0;
            r_overflow     <= 1'b0;
            r_tile_wb_done <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_tile_wb_done <= (w_state_next == DONE);
            if (w_clr_cnt) begin
                r_words <= '0;
            end else if (w_pop) begin
                r_words <= r_words + CNT_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign fifo_full     = w_fifo_full;
    assign mem_wr_valid  = w_fifo_valid;
    assign mem_wr_addr   = w_head.addr;
    assign mem_wr_data   = w_head.data;
    assign tile_wb_done  = r_tile_wb_done;
    assign words_written = r_words;
    assign overflow_err  = r_overflow;

endmodule
